trng_health_packer: RTL and testbench



---
 rtl/trng_pkg.sv | 12 +
 rtl/trng_byte_fifo.sv | 68 ++++++
 rtl/trng_health_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_trng_health_packer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG health-test / byte-packer block.
package trng_pkg;
  localparam int BYTE_W   = 8;
  localparam int FAIL_RCT = 0;
  localparam int FAIL_APT = 1;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    FAIL    = 2'd2
  } trng_state_e;
endpackage

// File: rtl/trng_byte_fifo.sv
// Small synchronous byte FIFO; a pop in the same cycle frees room for a push when full.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [BYTE_W-1:0] pop_data
);
  logic [DEPTH-1:0][BYTE_W-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign pop_valid = (count_q != '0);
  assign pop_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = pop_valid && pop_ready;
    push_ok  = push && (!full || pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/trng_health_packer.sv
// Health-tests the tinytrng bit stream (RCT + APT) and packs approved bits into bytes.
// Optional von Neumann corrector before the packer: define TRNG_VN_DEBIAS_EN.
module trng_health_packer
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF   = 32,
  parameter int APT_WINDOW   = 1024,
  parameter int APT_CUTOFF   = 589,
  parameter int STARTUP_BITS = 1024,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              random,
  input  logic              bclk,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              running,
  output logic              alarm,
  output logic [1:0]        fail_code,
  output logic [7:0]        drop_cnt
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int PW = $clog2(APT_WINDOW);
  localparam int MW = $clog2(APT_WINDOW + 1);
  localparam int SW = $clog2(STARTUP_BITS + 1);
  localparam int BW = $clog2(BYTE_W);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [RW-1:0] RCT_CUT  = RW'(RCT_CUTOFF);
  localparam logic [MW-1:0] APT_CUT  = MW'(APT_CUTOFF);
  localparam logic [SW-1:0] SU_LAST  = SW'(STARTUP_BITS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BYTE_W - 1);

  logic random_s1_q, random_s2_q;
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic bit_evt, bit_in, active, fail_now, rct_hit, apt_hit, pack_evt, flush;
  logic emit, emit_bit;

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          ref_q, ref_d;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] startup_q, startup_d;
  logic [1:0]    fail_code_q, fail_code_d;
  trng_state_e   state_q, state_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          push_q, push_d;
  logic [7:0]    drop_q, drop_d;
`ifdef TRNG_VN_DEBIAS_EN
  logic          vn_phase_q, vn_phase_d, vn_first_q, vn_first_d;
`endif

  logic              fifo_full, fifo_valid, fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_W-1:0] fifo_data;

  // random and bclk share sync depth so the bit is aligned with its strobe
  assign bit_evt = bclk_s2_q & ~bclk_s3_q;
  assign bit_in  = random_s2_q;
  assign active  = bit_evt && (state_q != FAIL);

  always_comb begin
    run_d   = run_q;
    last_d  = last_q;
    pos_d   = pos_q;
    ref_d   = ref_q;
    match_d = match_q;
    rct_hit = 1'b0;
    apt_hit = 1'b0;
    if (active) begin
      if (run_q != '0 && bit_in == last_q) begin
        if (run_q != RCT_CUT) run_d = run_q + 1'b1;
      end else begin
        run_d = RW'(1);
      end
      last_d  = bit_in;
      rct_hit = (run_d == RCT_CUT);
      if (pos_q == '0) begin
        ref_d   = bit_in;
        match_d = MW'(1);
      end else if (bit_in == ref_q) begin
        match_d = match_q + 1'b1;
      end
      apt_hit = (match_d == APT_CUT);
      pos_d   = pos_q + 1'b1;
    end
  end

  assign fail_now = rct_hit | apt_hit;

  always_comb begin
    state_d     = state_q;
    startup_d   = startup_q;
    fail_code_d = fail_code_q;
    fail_code_d[FAIL_RCT] = fail_code_q[FAIL_RCT] | rct_hit;
    fail_code_d[FAIL_APT] = fail_code_q[FAIL_APT] | apt_hit;
    case (state_q)
      STARTUP: if (active) begin
        if (fail_now)                state_d = FAIL;
        else if (startup_q == SU_LAST) state_d = RUN;
        else                         startup_d = startup_q + 1'b1;
      end
      RUN:     if (fail_now) state_d = FAIL;
      default: state_d = FAIL;
    endcase
    flush = (state_q != FAIL) && (state_d == FAIL);
  end

  assign pack_evt = active && (state_q == RUN) && !fail_now;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    push_d = 1'b0;
    drop_d = drop_q;
`ifdef TRNG_VN_DEBIAS_EN
    vn_phase_d = vn_phase_q;
    vn_first_d = vn_first_q;
    emit       = 1'b0;
    emit_bit   = vn_first_q;
    if (state_q == STARTUP && state_d == RUN) vn_phase_d = 1'b0;
    if (pack_evt) begin
      if (!vn_phase_q) begin
        vn_first_d = bit_in;
        vn_phase_d = 1'b1;
      end else begin
        vn_phase_d = 1'b0;
        emit       = (vn_first_q != bit_in);
      end
    end
`else
    emit     = pack_evt;
    emit_bit = bit_in;
`endif
    if (emit) begin
      sr_d  = {emit_bit, sr_q[BYTE_W-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == BIT_LAST) push_d = 1'b1;
    end
    if (flush) begin
      sr_d   = '0;
      cnt_d  = '0;
      push_d = 1'b0;
    end
    if (push_q && fifo_full && !fifo_pop && !flush && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_s1_q <= 1'b0;
      random_s2_q <= 1'b0;
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      run_q       <= '0;
      last_q      <= 1'b0;
      pos_q       <= '0;
      ref_q       <= 1'b0;
      match_q     <= '0;
      startup_q   <= '0;
      fail_code_q <= '0;
      state_q     <= STARTUP;
      sr_q        <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      drop_q      <= '0;
`ifdef TRNG_VN_DEBIAS_EN
      vn_phase_q  <= 1'b0;
      vn_first_q  <= 1'b0;
`endif
    end else begin
      random_s1_q <= random;
      random_s2_q <= random_s1_q;
      bclk_s1_q   <= bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      run_q       <= run_d;
      last_q      <= last_d;
      pos_q       <= pos_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      startup_q   <= startup_d;
      fail_code_q <= fail_code_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      drop_q      <= drop_d;
`ifdef TRNG_VN_DEBIAS_EN
      vn_phase_q  <= vn_phase_d;
      vn_first_q  <= vn_first_d;
`endif
    end
  end

  // sr_q still holds the completed byte one cycle after the 8th bit
  trng_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (push_q),
    .push_data (sr_q),
    .full      (fifo_full),
    .count     (fifo_count),
    .pop_valid (fifo_valid),
    .pop_ready (ready),
    .pop_data  (fifo_data)
  );

  assign fifo_pop  = fifo_valid && ready;
  assign valid     = fifo_valid;
  assign data      = (fifo_count != '0) ? fifo_data : '0;
  assign running   = (state_q == RUN);
  assign alarm     = (state_q == FAIL);
  assign fail_code = fail_code_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_trng_health_packer.sv
// Randomized bench for trng_health_packer against a rule-level model of the bit stream.
module tb_trng_health_packer;
  localparam int RCT_CUTOFF   = 32;
  localparam int APT_WINDOW   = 1024;
  localparam int APT_CUTOFF   = 589;
  localparam int STARTUP_BITS = 1024;
  localparam int FIFO_DEPTH   = 4;

  logic       clk = 1'b0, resetn = 1'b0, random = 1'b0, bclk = 1'b0, ready = 1'b0;
  logic [7:0] data, drop_cnt;
  logic       valid, running, alarm;
  logic [1:0] fail_code;

  always #5 clk = ~clk;

  trng_health_packer dut (
    .clk(clk), .resetn(resetn), .random(random), .bclk(bclk),
    .data(data), .valid(valid), .ready(ready), .running(running),
    .alarm(alarm), .fail_code(fail_code), .drop_cnt(drop_cnt)
  );

  int n_tests = 0, n_fail = 0, n_xfer = 0;

  // reference model state
  int         m_n, m_run, m_match, m_nb, m_drop, m_made;
  bit         m_last, m_ref, m_failed, m_vn_have, m_vn_first;
  logic [1:0] m_fc;
  bit   [7:0] m_sr;
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    m_n = 0; m_run = 0; m_match = 0; m_nb = 0; m_drop = 0; m_made = 0;
    m_last = 0; m_ref = 0; m_failed = 0; m_vn_have = 0; m_vn_first = 0;
    m_fc = 2'b00; m_sr = 8'h00;
    exp_q.delete();
  endfunction

  function automatic bit exp_running();
    return !m_failed && (m_n >= STARTUP_BITS);
  endfunction

  function automatic void model_bit(input bit b);
    bit rf, af, pb;
    if (m_failed) return;
    m_run  = (m_n > 0 && b == m_last) ? m_run + 1 : 1;
    m_last = b;
    if (m_n % APT_WINDOW == 0) begin m_ref = b; m_match = 1; end
    else if (b == m_ref) m_match++;
    rf = (m_run >= RCT_CUTOFF);
    af = (m_match >= APT_CUTOFF);
    m_n++;
    if (rf || af) begin
      m_failed = 1; m_fc = m_fc | {af, rf};
      exp_q.delete(); m_sr = 0; m_nb = 0;
      return;
    end
    if (m_n <= STARTUP_BITS) return;
`ifdef TRNG_VN_DEBIAS_EN
    if (!m_vn_have) begin m_vn_have = 1; m_vn_first = b; return; end
    m_vn_have = 0;
    if (m_vn_first == b) return;
    pb = m_vn_first;
`else
    pb = b;
`endif
    m_sr[m_nb] = pb;
    m_nb++;
    if (m_nb == 8) begin
      m_nb = 0; m_made++;
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(m_sr);
      else if (m_drop < 255) m_drop++;
    end
  endfunction

  // caller is just after a falling clk edge; v2/v3 sample valid before/after the bit-event edge
  task automatic drive_bit(input bit b, output logic v2, output logic v3);
    model_bit(b);
    random = b; bclk = 1'b1;
    @(negedge clk); @(negedge clk); v2 = valid;
    @(negedge clk); v3 = valid;
    bclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    logic a, c;
    drive_bit(b, a, c);
  endtask

  // consumer-side monitor: every transfer must match the model's next byte
  logic [7:0] hold_data;
  bit         hold_v = 0;
  always @(negedge clk) begin
    #1;
    if (resetn && valid) begin
      if (ready) begin
        n_tests++; n_xfer++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL xfer_unexpected: got data %h, model expects no byte", data);
        end else begin
          if (data !== exp_q[0]) begin
            n_fail++; $display("FAIL xfer_data: got %h, expected %h", data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        hold_v = 0;
      end else begin
        if (hold_v) begin
          n_tests++;
          if (data !== hold_data) begin
            n_fail++; $display("FAIL data_stable: got %h, held %h", data, hold_data);
          end
        end
        hold_v = 1; hold_data = data;
      end
    end else hold_v = 0;
  end

  task automatic do_reset();
    resetn = 1'b0; bclk = 1'b0; random = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 6;
    if (running !== 1'b0)    begin n_fail++; $display("FAIL rst_running: got %b, expected 0", running); end
    if (alarm !== 1'b0)      begin n_fail++; $display("FAIL rst_alarm: got %b, expected 0", alarm); end
    if (fail_code !== 2'b00) begin n_fail++; $display("FAIL rst_fail_code: got %b, expected 00", fail_code); end
    if (drop_cnt !== 8'd0)   begin n_fail++; $display("FAIL rst_drop_cnt: got %0d, expected 0", drop_cnt); end
    if (valid !== 1'b0)      begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", valid); end
    if (data !== 8'h00)      begin n_fail++; $display("FAIL rst_data: got %h, expected 00", data); end
  endtask

  task automatic test_startup();
    ready = 1'b1;
    for (int i = 0; i < STARTUP_BITS + 32; i++) begin
      send_bit((i % 2) == 1);
      if (i == STARTUP_BITS - 2 || i == STARTUP_BITS - 1) begin
        n_tests += 2;
        if (running !== exp_running()) begin n_fail++; $display("FAIL su_running bit %0d: got %b, expected %b", i, running, exp_running()); end
        if (n_xfer !== 0) begin n_fail++; $display("FAIL su_no_output bit %0d: got %0d transfers, expected 0", i, n_xfer); end
      end
    end
    repeat (4) @(negedge clk);
    n_tests += 3;
    if (n_xfer !== m_made) begin n_fail++; $display("FAIL su_bytes: got %0d transfers, expected %0d", n_xfer, m_made); end
    if (alarm !== 1'b0)    begin n_fail++; $display("FAIL su_alarm: got %b, expected 0", alarm); end
    if (running !== 1'b1)  begin n_fail++; $display("FAIL su_running_end: got %b, expected 1", running); end
  endtask

  task automatic test_back_to_back();
    int x0, pend;
    ready = 1'b0;
    x0 = n_xfer;
    for (int i = 0; i < 48; i++) send_bit(!m_last);
    pend = exp_q.size();
    n_tests += 3;
    if (drop_cnt !== m_drop[7:0]) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d, expected %0d", drop_cnt, m_drop); end
    if (valid !== (pend > 0))     begin n_fail++; $display("FAIL bp_valid: got %b, expected %b", valid, pend > 0); end
    if (n_xfer !== x0)            begin n_fail++; $display("FAIL bp_no_xfer: got %0d, expected %0d", n_xfer, x0); end
    ready = 1'b1;
    repeat (10) @(negedge clk);
    n_tests += 2;
    if (n_xfer - x0 !== pend) begin n_fail++; $display("FAIL bp_drain: got %0d transfers, expected %0d", n_xfer - x0, pend); end
    if (valid !== 1'b0)       begin n_fail++; $display("FAIL bp_empty: got valid %b, expected 0", valid); end
  endtask

  task automatic test_apt();
    logic v2, v3;
    int   pre, guard;
    ready = 1'b1;
    while (m_n % APT_WINDOW != 0) send_bit(!m_last);
    ready = 1'b0;
    guard = 0;
    while (!m_failed && guard < APT_WINDOW) begin
      int k = $urandom_range(1, 3);
      for (int j = 0; j <= k && !m_failed; j++) begin
        pre = exp_q.size();
        drive_bit(j != k, v2, v3);
        guard++;
        if (m_failed) begin
          n_tests += 2;
          if (v2 !== (pre > 0)) begin n_fail++; $display("FAIL apt_valid_before: got %b, expected %b", v2, pre > 0); end
          if (v3 !== 1'b0)      begin n_fail++; $display("FAIL apt_valid_next: got %b, expected 0", v3); end
        end
      end
    end
    n_tests += 5;
    if (m_failed !== 1'b1)   begin n_fail++; $display("FAIL apt_model_trip: got %b, expected 1", m_failed); end
    if (fail_code !== m_fc)  begin n_fail++; $display("FAIL apt_fail_code: got %b, expected %b", fail_code, m_fc); end
    if (alarm !== 1'b1)      begin n_fail++; $display("FAIL apt_alarm: got %b, expected 1", alarm); end
    if (running !== 1'b0)    begin n_fail++; $display("FAIL apt_running: got %b, expected 0", running); end
    if (drop_cnt !== m_drop[7:0]) begin n_fail++; $display("FAIL apt_drop_cnt: got %0d, expected %0d", drop_cnt, m_drop); end
  endtask

  task automatic test_rct();
    int x0;
    do_reset();
    ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < RCT_CUTOFF; i++) begin
      send_bit(1'b1);
      if (i == RCT_CUTOFF - 2) begin
        n_tests++;
        if (alarm !== 1'b0) begin n_fail++; $display("FAIL rct_early: got alarm %b at bit %0d, expected 0", alarm, i + 1); end
      end
    end
    n_tests += 3;
    if (alarm !== 1'b1)      begin n_fail++; $display("FAIL rct_alarm: got %b, expected 1", alarm); end
    if (fail_code !== m_fc)  begin n_fail++; $display("FAIL rct_fail_code: got %b, expected %b", fail_code, m_fc); end
    if (running !== 1'b0)    begin n_fail++; $display("FAIL rct_running: got %b, expected 0", running); end
    for (int i = 0; i < 10; i++) send_bit($urandom_range(0, 1) == 1);
    n_tests += 4;
    if (fail_code !== 2'b01) begin n_fail++; $display("FAIL rct_sticky: got %b, expected 01", fail_code); end
    if (alarm !== 1'b1)      begin n_fail++; $display("FAIL rct_alarm_sticky: got %b, expected 1", alarm); end
    if (valid !== 1'b0)      begin n_fail++; $display("FAIL rct_valid: got %b, expected 0", valid); end
    if (n_xfer !== x0)       begin n_fail++; $display("FAIL rct_no_output: got %0d transfers, expected %0d", n_xfer, x0); end
  endtask

  task automatic test_reset_mid();
    int x0, made0, guard;
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < STARTUP_BITS; i++) send_bit((i % 2) == 1);
    ready = 1'b0;
    guard = 0;
    while (exp_q.size() == 0 && guard < 64) begin send_bit(!m_last); guard++; end
    repeat (2) @(negedge clk);
    n_tests += 2;
    if (valid !== 1'b1)   begin n_fail++; $display("FAIL mid_valid_pre: got %b, expected 1", valid); end
    if (running !== 1'b1) begin n_fail++; $display("FAIL mid_running_pre: got %b, expected 1", running); end
    #2 resetn = 1'b0;
    #1;
    n_tests += 4;
    if (valid !== 1'b0)   begin n_fail++; $display("FAIL mid_valid: got %b, expected 0", valid); end
    if (running !== 1'b0) begin n_fail++; $display("FAIL mid_running: got %b, expected 0", running); end
    if (data !== 8'h00)   begin n_fail++; $display("FAIL mid_data: got %h, expected 00", data); end
    if (alarm !== 1'b0)   begin n_fail++; $display("FAIL mid_alarm: got %b, expected 0", alarm); end
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < STARTUP_BITS; i++) send_bit((i % 2) == 1);
    n_tests += 2;
    if (n_xfer !== x0)    begin n_fail++; $display("FAIL mid_restart_quiet: got %0d transfers, expected %0d", n_xfer, x0); end
    if (running !== 1'b1) begin n_fail++; $display("FAIL mid_restart_run: got %b, expected 1", running); end
    made0 = m_made;
    for (int i = 0; i < 32; i++) send_bit(!m_last);
    repeat (4) @(negedge clk);
    n_tests++;
    if (n_xfer - x0 !== m_made - made0) begin n_fail++; $display("FAIL mid_restart_bytes: got %0d, expected %0d", n_xfer - x0, m_made - made0); end
  endtask

  task automatic test_random();
    bit v;
    int total, len;
    do_reset();
    ready = 1'b1;
    v = ($urandom_range(0, 1) == 1);
    total = 0;
    while (!m_failed && total < 1600) begin
      if (m_n >= STARTUP_BITS && $urandom_range(0, 29) == 0) len = $urandom_range(20, 40);
      else len = $urandom_range(1, 4);
      for (int j = 0; j < len && !m_failed; j++) begin send_bit(v); total++; end
      v = !v;
      n_tests += 3;
      if (running !== exp_running()) begin n_fail++; $display("FAIL rnd_running bit %0d: got %b, expected %b", m_n, running, exp_running()); end
      if (alarm !== m_failed)        begin n_fail++; $display("FAIL rnd_alarm bit %0d: got %b, expected %b", m_n, alarm, m_failed); end
      if (fail_code !== m_fc)        begin n_fail++; $display("FAIL rnd_fail_code bit %0d: got %b, expected %b", m_n, fail_code, m_fc); end
    end
    repeat (8) @(negedge clk);
    n_tests += 2;
    if (exp_q.size() != 0)        begin n_fail++; $display("FAIL rnd_pending: %0d expected bytes never delivered", exp_q.size()); end
    if (drop_cnt !== m_drop[7:0]) begin n_fail++; $display("FAIL rnd_drop_cnt: got %0d, expected %0d", drop_cnt, m_drop); end
  endtask

`ifdef TRNG_VN_DEBIAS_EN
  task automatic test_vn();
    int x0;
    logic [7:0] pat;
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < STARTUP_BITS; i++) send_bit((i % 2) == 1);
    x0  = n_xfer;
    pat = 8'b0011_0110;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) send_bit(pat[j]);
    repeat (4) @(negedge clk);
    n_tests += 2;
    if (n_xfer - x0 !== 2)  begin n_fail++; $display("FAIL vn_bytes: got %0d transfers, expected 2", n_xfer - x0); end
    if (exp_q.size() != 0)  begin n_fail++; $display("FAIL vn_pending: %0d bytes not delivered", exp_q.size()); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_back_to_back();
    test_apt();
    test_rct();
    test_reset_mid();
`ifdef TRNG_VN_DEBIAS_EN
    test_vn();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
